// File: rtl/debounce_fsm.sv
// -----------------------------------------------------------------------------
// debounce_fsm
//   Debounces a joystick push-button level. The raw input is synchronised into
//   clk, then a four-state FSM accepts a level change only after the
//   synchronised input has stayed put for STABLE_TICKS consecutive timer ticks.
//
// Ports
//   clk       in   clock
//   reset_n   in   asynchronous, active-low reset
//   noisy_in  in   raw button level, asynchronous to clk
//   tick      in   1-cycle timer 'done' pulse (clk domain)
//   timer_en  out  timer enable, high while qualifying a change (WAIT1/WAIT0)
//   db_level  out  debounced level
//   db_rise   out  1-cycle pulse on an accepted 0->1
//   db_fall   out  1-cycle pulse on an accepted 1->0
// -----------------------------------------------------------------------------
module debounce_fsm #(
    parameter int unsigned STABLE_TICKS = 3,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic noisy_in,
    input  logic tick,
    output logic timer_en,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sw_s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    // Metastability synchroniser for the asynchronous button level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in};
        end
    end

    assign sw_s = sync_q[SYNC_STAGES-1];

    // Debounce FSM; outputs are updated together with the state transition so
    // they always reflect the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ZERO;
            cnt      <= '0;
            timer_en <= 1'b0;
            db_level <= 1'b0;
            db_rise  <= 1'b0;
            db_fall  <= 1'b0;
        end else begin
            db_rise <= 1'b0;
            db_fall <= 1'b0;

            case (state)
                ZERO: begin
                    if (sw_s) begin
                        state    <= WAIT1;
                        cnt      <= '0;
                        timer_en <= 1'b1;
                    end
                end

                // Input must not move while ticks are counted; an abort wins
                // over a coincident tick.
                WAIT1: begin
                    if (!sw_s) begin
                        state    <= ZERO;
                        cnt      <= '0;
                        timer_en <= 1'b0;
                    end else if (tick) begin
                        if (cnt == CNT_LAST) begin
                            state    <= ONE;
                            cnt      <= '0;
                            timer_en <= 1'b0;
                            db_level <= 1'b1;
                            db_rise  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                ONE: begin
                    if (!sw_s) begin
                        state    <= WAIT0;
                        cnt      <= '0;
                        timer_en <= 1'b1;
                    end
                end

                WAIT0: begin
                    if (sw_s) begin
                        state    <= ONE;
                        cnt      <= '0;
                        timer_en <= 1'b0;
                    end else if (tick) begin
                        if (cnt == CNT_LAST) begin
                            state    <= ZERO;
                            cnt      <= '0;
                            timer_en <= 1'b0;
                            db_level <= 1'b0;
                            db_fall  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state    <= ZERO;
                    cnt      <= '0;
                    timer_en <= 1'b0;
                    db_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_fsm.sv
// -----------------------------------------------------------------------------
// tb_debounce_fsm
//   Scenario bench for debounce_fsm (STABLE_TICKS=3, tick every 10 cycles).
//   Each scenario pushes the pulses it expects (1=rise, 0=fall) onto exp_q as
//   it drives the button; a negedge monitor pops one entry per observed pulse
//   and also checks that exactly STABLE_TICKS ticks were seen in the wait state.
// -----------------------------------------------------------------------------
module tb_debounce_fsm;

    localparam int unsigned STABLE_TICKS = 3;
    localparam int unsigned SYNC_STAGES  = 2;
    localparam int          TICK_PERIOD  = 10;
    localparam int          LEVEL_BOUND  = 70;

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic noisy_in = 1'b1;
    logic tick     = 1'b0;
    logic timer_en;
    logic db_level;
    logic db_rise;
    logic db_fall;

    int n_cmp      = 0;
    int n_err      = 0;
    int tdiv       = 0;
    int wait_ticks = 0;
    bit exp_q[$];
    bit exp_k;
    bit prev_rise  = 1'b0;
    bit prev_fall  = 1'b0;

    debounce_fsm #(
        .STABLE_TICKS(STABLE_TICKS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .noisy_in(noisy_in),
        .tick    (tick),
        .timer_en(timer_en),
        .db_level(db_level),
        .db_rise (db_rise),
        .db_fall (db_fall)
    );

    always #5 clk = ~clk;

    // Free-running timer tick: one cycle high every TICK_PERIOD cycles
    always @(posedge clk) begin
        #1;
        tick = (tdiv == TICK_PERIOD - 1);
        tdiv = (tdiv == TICK_PERIOD - 1) ? 0 : tdiv + 1;
    end

    // Pulse monitor / scoreboard consumer
    always @(negedge clk) begin
        if (!reset_n) begin
            wait_ticks = 0;
            prev_rise  = 1'b0;
            prev_fall  = 1'b0;
        end else begin
            if (db_rise || db_fall) begin
                n_cmp++;
                if (db_rise && db_fall) begin
                    n_err++;
                    $display("FAIL pulse_exclusive: got rise=%0b fall=%0b, required not both", db_rise, db_fall);
                end
                n_cmp++;
                if ((db_rise && prev_rise) || (db_fall && prev_fall)) begin
                    n_err++;
                    $display("FAIL pulse_width: pulse high for 2+ cycles at %0t, required 1 cycle", $time);
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got rise=%0b fall=%0b at %0t, required no pulse", db_rise, db_fall, $time);
                end else begin
                    exp_k = exp_q.pop_front();
                    n_cmp++;
                    if (db_rise !== exp_k) begin
                        n_err++;
                        $display("FAIL pulse_kind: got rise=%0b, required rise=%0b", db_rise, exp_k);
                    end
                    n_cmp++;
                    if (db_level !== exp_k) begin
                        n_err++;
                        $display("FAIL pulse_level: got db_level=%0b, required %0b", db_level, exp_k);
                    end
                    n_cmp++;
                    if (wait_ticks != int'(STABLE_TICKS)) begin
                        n_err++;
                        $display("FAIL accept_ticks: got %0d ticks in wait, required %0d", wait_ticks, STABLE_TICKS);
                    end
                end
            end
            prev_rise = db_rise;
            prev_fall = db_fall;
            if (timer_en) wait_ticks = wait_ticks + int'(tick);
            else          wait_ticks = 0;
        end
    end

    task automatic wait_level(input logic v, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (db_level === v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns once the monitor has counted n ticks in the current wait state
    task automatic wait_for_ticks(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (timer_en && wait_ticks >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_button(input logic v);
        @(posedge clk);
        #1;
        noisy_in = v;
    endtask

    task automatic test_clean_release();
        bit ok;
        exp_q.push_back(1'b0);
        drive_button(1'b0);
        wait_level(1'b0, LEVEL_BOUND, ok);
        n_cmp++;
        if (!ok || db_level !== 1'b0) begin
            n_err++;
            $display("FAIL release_level: got db_level=%0b (in bound=%0b), required 0", db_level, ok);
        end
    endtask

    task automatic test_reset();
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({db_level, db_rise, db_fall, timer_en} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: got lvl/rise/fall/ten=%b, required 0000", {db_level, db_rise, db_fall, timer_en});
        end
        exp_q.push_back(1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        n_cmp++;
        if (db_level !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_instant: got db_level=%0b 15 cycles after release, required 0", db_level);
        end
        wait_level(1'b1, LEVEL_BOUND, ok);
        n_cmp++;
        if (!ok || db_level !== 1'b1) begin
            n_err++;
            $display("FAIL reset_accept: got db_level=%0b (in bound=%0b), required 1", db_level, ok);
        end
        test_clean_release();
    endtask

    task automatic test_clean_press();
        bit ok;
        exp_q.push_back(1'b1);
        drive_button(1'b1);
        repeat (SYNC_STAGES + 1) @(negedge clk);
        n_cmp++;
        if (timer_en !== 1'b0) begin
            n_err++;
            $display("FAIL timer_en_early: got %0b before sync latency elapsed, required 0", timer_en);
        end
        @(negedge clk);
        n_cmp++;
        if (timer_en !== 1'b1) begin
            n_err++;
            $display("FAIL timer_en_start: got %0b %0d cycles after press, required 1", timer_en, SYNC_STAGES + 1);
        end
        wait_level(1'b1, LEVEL_BOUND, ok);
        n_cmp++;
        if (!ok || db_level !== 1'b1) begin
            n_err++;
            $display("FAIL press_level: got db_level=%0b (in bound=%0b), required 1", db_level, ok);
        end
        n_cmp++;
        if (timer_en !== 1'b0) begin
            n_err++;
            $display("FAIL timer_en_stop: got %0b on accept, required 0", timer_en);
        end
        test_clean_release();
    endtask

    task automatic test_bounce();
        bit ok;
        logic v;
        v = 1'b0;
        for (int i = 0; i < 15; i++) begin
            v = ~v;
            drive_button(v);
            repeat (3) @(posedge clk);
        end
        drive_button(1'b0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (db_level !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_level: got db_level=%0b after bounce, required 0", db_level);
        end
        exp_q.push_back(1'b1);
        drive_button(1'b1);
        wait_level(1'b1, LEVEL_BOUND, ok);
        n_cmp++;
        if (!ok || db_level !== 1'b1) begin
            n_err++;
            $display("FAIL bounce_settle: got db_level=%0b (in bound=%0b), required 1", db_level, ok);
        end
    endtask

    // Entered with db_level=1
    task automatic test_release_glitch();
        bit ok;
        drive_button(1'b0);
        repeat (2) @(posedge clk);
        drive_button(1'b1);
        repeat (20) @(negedge clk);
        drive_button(1'b0);
        wait_for_ticks(2, 40, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL glitch_wait0: got %0d ticks in WAIT0, required 2", wait_ticks);
        end
        drive_button(1'b1);
        repeat (40) @(negedge clk);
        n_cmp++;
        if (db_level !== 1'b1 || timer_en !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_hold: got lvl=%0b ten=%0b, required lvl=1 ten=0", db_level, timer_en);
        end
        test_clean_release();
    endtask

    task automatic test_abort_on_tick();
        bit ok;
        drive_button(1'b1);
        wait_for_ticks(2, 40, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL abort_setup: got %0d ticks in WAIT1, required 2", wait_ticks);
        end
        // Drop the input so the synchronised 0 lands with the 3rd tick
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (tdiv == TICK_PERIOD - 2) begin
                noisy_in = 1'b0;
                break;
            end
        end
        repeat (30) @(negedge clk);
        n_cmp++;
        if (db_level !== 1'b0 || timer_en !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state: got lvl=%0b ten=%0b, required lvl=0 ten=0", db_level, timer_en);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        drive_button(1'b1);
        wait_for_ticks(2, 40, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL rstmid_setup: got %0d ticks in WAIT1, required 2", wait_ticks);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({db_level, db_rise, db_fall, timer_en} !== 4'b0000) begin
            n_err++;
            $display("FAIL rstmid_async: got lvl/rise/fall/ten=%b, required 0000", {db_level, db_rise, db_fall, timer_en});
        end
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(1'b1);
        reset_n = 1'b1;
        repeat (SYNC_STAGES + 2) @(negedge clk);
        n_cmp++;
        if (timer_en !== 1'b1 || db_level !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_requalify: got ten=%0b lvl=%0b, required ten=1 lvl=0", timer_en, db_level);
        end
        wait_level(1'b1, LEVEL_BOUND, ok);
        n_cmp++;
        if (!ok || db_level !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_accept: got db_level=%0b (in bound=%0b), required 1", db_level, ok);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_abort_on_tick();
        test_reset_mid_wait();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_pulses: got %0d expected pulses never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
